// File: rtl/spi_read_adc.sv
// spi_read_adc: SPI master read engine (CPOL=0, CPHA=0) for the ADC front end.
// A start strobe drops chip-select, runs sck_o from a programmable half-period
// divider and shifts in one MSB-first word on miso_i. The word is then presented
// on dout_o together with a one-cycle eor_o pulse.
// Optional build macro: MISO_SYNC_EN
//   defined   - miso_i goes through a 2-flop synchronizer, is sampled in the last
//               clk cycle of each sck-high phase, and H is clamped to >= 3.
//   undefined - miso_i is sampled directly on the sck_o rising edge.
module spi_read_adc #(
    parameter int Width  = 16,
    parameter int KWidth = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              strr_i,
    input  logic [KWidth-1:0] kmax_i,
    input  logic              miso_i,
    output logic              sck_o,
    output logic              cs_o,
    output logic [Width-1:0]  dout_o,
    output logic              eor_o,
    output logic              busy_o
);

    localparam int CW = $clog2(Width + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic [KWidth-1:0] r_hm1;
    logic [KWidth-1:0] r_div;
    logic [CW-1:0]     r_bits;
    logic [Width-1:0]  r_shift;
    logic [Width-1:0]  r_dout;
    logic              r_sck;
    logic              r_cs;
    logic              r_eor;
    logic              r_busy;

    logic              w_div_done;
    logic              w_last_bit;
    logic              w_miso;
    logic [KWidth-1:0] w_hm1_start;

    assign w_div_done = (r_div == r_hm1);
    assign w_last_bit = (r_bits == CW'(1));

`ifdef MISO_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchronizer on the asynchronous serial input
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], miso_i};
        end
    end

    assign w_miso      = r_sync[1];
    // The synchronizer latency needs at least three clk cycles per sck phase
    assign w_hm1_start = (kmax_i < KWidth'(2)) ? KWidth'(2) : kmax_i;
`else
    assign w_miso      = miso_i;
    assign w_hm1_start = kmax_i;
`endif

    // Frame sequencer: divider, bit counter, shift register and all outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_hm1   <= '0;
            r_div   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_sck   <= 1'b0;
            r_cs    <= 1'b1;
            r_eor   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_eor <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cs  <= 1'b1;
                    r_sck <= 1'b0;
                    if (strr_i) begin
                        r_hm1   <= w_hm1_start;
                        r_div   <= '0;
                        r_shift <= '0;
                        r_bits  <= CW'(Width);
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_state <= S_HIGH;
`ifndef MISO_SYNC_EN
                        r_shift <= {r_shift[Width-2:0], w_miso};
`endif
                    end else begin
                        r_div <= r_div + KWidth'(1);
                    end
                end

                S_HIGH: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_sck   <= 1'b0;
                        r_state <= S_LOW;
`ifdef MISO_SYNC_EN
                        r_shift <= {r_shift[Width-2:0], w_miso};
`endif
                    end else begin
                        r_div <= r_div + KWidth'(1);
                    end
                end

                S_LOW: begin
                    if (w_div_done) begin
                        r_div  <= '0;
                        r_bits <= r_bits - CW'(1);
                        if (w_last_bit) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_sck   <= 1'b1;
                            r_state <= S_HIGH;
`ifndef MISO_SYNC_EN
                            r_shift <= {r_shift[Width-2:0], w_miso};
`endif
                        end
                    end else begin
                        r_div <= r_div + KWidth'(1);
                    end
                end

                S_HOLD: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_cs    <= 1'b1;
                        r_dout  <= r_shift;
                        r_eor   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + KWidth'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sck_o  = r_sck;
    assign cs_o   = r_cs;
    assign dout_o = r_dout;
    assign eor_o  = r_eor;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_spi_read_adc.sv
// tb_spi_read_adc: table-driven frames with an ADC slave model and a scoreboard
// popped on every eor_o, plus hand-written strobe, back-to-back and reset cases.
module tb_spi_read_adc;

    localparam int W  = 16;
    localparam int KW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          strr_i;
    logic [KW-1:0] kmax_i;
    logic          miso_i = 1'b0;
    logic          sck_o;
    logic          cs_o;
    logic [W-1:0]  dout_o;
    logic          eor_o;
    logic          busy_o;

    spi_read_adc #(.Width(W), .KWidth(KW)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .strr_i (strr_i),
        .kmax_i (kmax_i),
        .miso_i (miso_i),
        .sck_o  (sck_o),
        .cs_o   (cs_o),
        .dout_o (dout_o),
        .eor_o  (eor_o),
        .busy_o (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] dout;
        int unsigned  low;
        int unsigned  rises;
    } exp_t;

    typedef struct {
        logic [KW-1:0] kmax;
        logic [W-1:0]  pattern;
        logic [W-1:0]  dout;
        int unsigned   low;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    int unsigned lowcnt = 0;
    int unsigned rises = 0;
    int unsigned eor_count = 0;
    int unsigned hicnt = 0;
    int unsigned last_gap = 0;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;

    logic [W-1:0] adc_word = '0;
    logic [W-1:0] adc_sh = '0;

    // sck half-period in clk cycles as seen on the wire
    function automatic int unsigned heff(input logic [KW-1:0] k);
`ifdef MISO_SYNC_EN
        if (k < 8'd2) return 3;
`endif
        return 32'(k) + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(negedge clk_i);
            #1;
        end
    endtask

    task automatic start_frame(input logic [KW-1:0] k, input logic [W-1:0] pat,
                               input logic [W-1:0] expd, input int unsigned low);
        exp_t e;
        kmax_i   = k;
        adc_word = pat;
        e.dout   = expd;
        e.low    = low;
        e.rises  = W;
        sb.push_back(e);
        strr_i = 1'b1;
        tick(1);
        strr_i = 1'b0;
    endtask

    task automatic wait_eor(input int unsigned target, input int unsigned budget, input string name);
        int unsigned n;
        n = 0;
        while (eor_count < target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(eor_count >= target), 32'd1);
    endtask

    // ADC slave: MSB valid when cs falls, next bit on each sck falling edge
    initial forever begin
        @(negedge cs_o);
        adc_sh = adc_word;
        miso_i = adc_sh[W-1];
    end

    initial forever begin
        @(negedge sck_o);
        if (cs_o === 1'b0) begin
            adc_sh = adc_sh << 1;
            miso_i = adc_sh[W-1];
        end
    end

    // Frame monitor: measures cs-low length, sck rises and gaps; checks on eor_o
    initial forever begin : mon
        exp_t e;
        @(negedge clk_i);
        if (rst_i === 1'b1) begin
            lowcnt   = 0;
            rises    = 0;
            hicnt    = 0;
            prev_sck = 1'b0;
            prev_cs  = 1'b1;
        end else begin
            if (cs_o === 1'b0) begin
                lowcnt++;
                if (prev_cs === 1'b1) last_gap = hicnt;
                hicnt = 0;
            end else begin
                hicnt++;
            end
            if (sck_o === 1'b1 && prev_sck === 1'b0) rises++;
            prev_sck = sck_o;
            prev_cs  = cs_o;
            if (eor_o === 1'b1) begin
                eor_count++;
                if (sb.size() == 0) begin
                    check("unexpected_eor", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("dout", 32'(dout_o), 32'(e.dout));
                    check("cs_low_cycles", lowcnt, e.low);
                    check("sck_rises", rises, e.rises);
                    check("busy_at_eor", 32'(busy_o), 32'd0);
                    check("cs_at_eor", 32'(cs_o), 32'd1);
                end
                lowcnt = 0;
                rises  = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int unsigned base;
        int unsigned n;

        rst_i  = 1'b1;
        strr_i = 1'b0;
        kmax_i = 8'd7;
        tick(3);
        check("rst_cs", 32'(cs_o), 32'd1);
        check("rst_sck", 32'(sck_o), 32'd0);
        check("rst_dout", 32'(dout_o), 32'd0);
        check("rst_eor", 32'(eor_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        tick(2);

        vecs[0] = '{8'd7,   16'hA5C3, 16'hA5C3, 34 * heff(8'd7)};
        vecs[1] = '{8'd0,   16'hFFFF, 16'hFFFF, 34 * heff(8'd0)};
        vecs[2] = '{8'd0,   16'h0001, 16'h0001, 34 * heff(8'd0)};
        vecs[3] = '{8'd3,   16'h1234, 16'h1234, 34 * heff(8'd3)};
        vecs[4] = '{8'd255, 16'h8001, 16'h8001, 34 * heff(8'd255)};
        vecs[5] = '{8'd0,   16'h5A5A, 16'h5A5A, 34 * heff(8'd0)};

        for (int i = 0; i < 6; i++) begin
            base = eor_count;
            start_frame(vecs[i].kmax, vecs[i].pattern, vecs[i].dout, vecs[i].low);
            check("busy_after_start", 32'(busy_o), 32'd1);
            check("cs_after_start", 32'(cs_o), 32'd0);
            kmax_i = ~vecs[i].kmax;
            wait_eor(base + 1, vecs[i].low + 20, "vec_eor_seen");
            tick(1);
            check("eor_one_cycle", 32'(eor_o), 32'd0);
            check("cs_idle", 32'(cs_o), 32'd1);
            tick(3);
        end

        // Strobes while busy are ignored and not queued
        base = eor_count;
        start_frame(8'd7, 16'h3C96, 16'h3C96, 34 * heff(8'd7));
        tick(3);
        strr_i = 1'b1;
        tick(1);
        strr_i = 1'b0;
        tick(94);
        strr_i = 1'b1;
        tick(1);
        strr_i = 1'b0;
        wait_eor(base + 1, 400, "repulse_eor_seen");
        tick(20);
        check("repulse_eor_count", eor_count, base + 1);
        check("repulse_cs_idle", 32'(cs_o), 32'd1);
        check("repulse_busy_idle", 32'(busy_o), 32'd0);

        // Strobe held high: back-to-back frames with a single-cycle cs-high gap
        base     = eor_count;
        kmax_i   = 8'd3;
        adc_word = 16'hC0DE;
        for (int i = 0; i < 3; i++) sb.push_back('{16'hC0DE, 34 * heff(8'd3), W});
        strr_i = 1'b1;
        wait_eor(base + 1, 200, "b2b_eor1");
        tick(1);
        check("b2b_gap1", last_gap, 1);
        check("b2b_cs_low1", 32'(cs_o), 32'd0);
        wait_eor(base + 2, 200, "b2b_eor2");
        tick(1);
        check("b2b_gap2", last_gap, 1);
        wait_eor(base + 3, 200, "b2b_eor3");
        strr_i = 1'b0;
        tick(5);
        check("b2b_stop_cs", 32'(cs_o), 32'd1);
        check("b2b_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of a frame
        base = eor_count;
        start_frame(8'd7, 16'hFFFF, 16'hFFFF, 34 * heff(8'd7));
        n = 0;
        while (rises < 8 && n < 400) begin
            tick(1);
            n++;
        end
        check("midrst_reached_bit8", 32'(rises >= 8), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        check("midrst_cs", 32'(cs_o), 32'd1);
        check("midrst_sck", 32'(sck_o), 32'd0);
        check("midrst_dout", 32'(dout_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        sb.delete();
        tick(2);
        rst_i = 1'b0;
        tick(2);
        check("midrst_no_eor", eor_count, base);
        start_frame(8'd5, 16'h6B1D, 16'h6B1D, 34 * heff(8'd5));
        wait_eor(base + 1, 300, "postrst_eor_seen");
        tick(3);
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
